mb_fetch_engine: RTL and testbench

- Parametrised successor to the intra-prediction macroblock extractor.
- On `start`, fetches one MB_W x MB_H source macroblock, then its top and left neighbour pixels, from external frame memory through a fixed-latency read port.
- Streams the pixels in a fixed order on a valid/ready byte interface to the intra predictor.
- Row/column is derived correctly from the MB index; neighbours come from the reconstructed frame; unavailable neighbours are replaced by 128.

---
 rtl/mb_fetch_engine.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mb_fetch_engine.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mb_fetch_engine.sv
// Macroblock + neighbour fetch engine feeding the intra predictor.
// Optional top-right fetch: define MB_FETCH_TOPRIGHT_EN.
module mb_fetch_engine #(
    parameter int FRAME_W = 1280,
    parameter int FRAME_H = 720,
    parameter int MB_W    = 16,
    parameter int MB_H    = 16,
    parameter int ADDR_W  = 20,
    parameter int MBN_W   = 13,
    parameter int RD_LAT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [MBN_W-1:0]  mbnumber,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd_en,
    output logic              mem_rd_sel,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [1:0]        out_kind,
    output logic              out_last
);
    localparam int MPR   = FRAME_W / MB_W;
    localparam int TOTAL = MPR * (FRAME_H / MB_H);
    localparam int DEPTH = RD_LAT + 2;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int KW    = $clog2(MB_W);
    localparam int JW    = $clog2(MB_H);
    localparam logic [ADDR_W-1:0] FW = ADDR_W'(FRAME_W);
    localparam logic [ADDR_W-1:0] MW = ADDR_W'(MB_W);
    localparam logic [KW-1:0] KMAX = KW'(MB_W - 1);
    localparam logic [JW-1:0] JMAX = JW'(MB_H - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_MB, S_TOP, S_LEFT, S_TR, S_DRAIN
    } state_t;

    state_t r_state, w_ns;
    logic [MBN_W-1:0]  r_mbn;
    logic [ADDR_W-1:0] r_x0, r_y0;
    logic [KW-1:0]     r_k;
    logic [JW-1:0]     r_j;
    logic              r_done, r_err;

    logic [RD_LAT-1:0]      r_sv, r_sc, r_sl;
    logic [RD_LAT-1:0][1:0] r_sk;

    logic [7:0]    r_fd [DEPTH];
    logic [1:0]    r_fk [DEPTH];
    logic          r_fl [DEPTH];
    logic [PW-1:0] r_rp, r_wp;
    logic [CW-1:0] r_cnt, w_infl;

    logic              w_slot, w_issue, w_credit, w_const, w_slast;
    logic              w_oor, w_done_n, w_err_n;
    logic              w_kend, w_jend;
    logic [1:0]        w_kind;
    logic [ADDR_W-1:0] w_row, w_col;
    logic              w_tv, w_fne, w_beat, w_push, w_pop;
    logic [7:0]        w_tdata;

    assign w_oor  = 32'(r_mbn) >= 32'(TOTAL);
    assign w_kend = r_k == KMAX;
    assign w_jend = r_j == JMAX;

    always_comb begin
        w_infl = '0;
        for (int i = 0; i < RD_LAT; i++)
            w_infl = w_infl + CW'(r_sv[i]);
    end

    assign w_credit = ({1'b0, r_cnt} + {1'b0, w_infl})
                      < (CW+1)'(DEPTH);

    always_comb begin
        w_ns     = r_state;
        w_slot   = 1'b0;
        w_kind   = 2'd0;
        w_const  = 1'b0;
        w_slast  = 1'b0;
        w_row    = '0;
        w_col    = '0;
        w_done_n = 1'b0;
        w_err_n  = 1'b0;
        w_issue  = 1'b0;
        unique case (r_state)
            S_IDLE: if (start) w_ns = S_CALC;
            S_CALC: begin
                if (w_oor) begin
                    w_ns     = S_IDLE;
                    w_done_n = 1'b1;
                    w_err_n  = 1'b1;
                end else begin
                    w_ns = S_MB;
                end
            end
            S_MB: begin
                w_slot  = 1'b1;
                w_issue = w_credit;
                w_row   = r_y0 + ADDR_W'(r_j);
                w_col   = r_x0 + ADDR_W'(r_k);
                if (w_issue && w_kend && w_jend) w_ns = S_TOP;
            end
            S_TOP: begin
                w_slot  = 1'b1;
                w_issue = w_credit;
                w_kind  = 2'd1;
                w_const = r_y0 == '0;
                w_row   = r_y0 - 1'b1;
                w_col   = r_x0 + ADDR_W'(r_k);
                if (w_issue && w_kend) w_ns = S_LEFT;
            end
            S_LEFT: begin
                w_slot  = 1'b1;
                w_issue = w_credit;
                w_kind  = 2'd2;
                w_const = r_x0 == '0;
                w_row   = r_y0 + ADDR_W'(r_j);
                w_col   = r_x0 - 1'b1;
`ifdef MB_FETCH_TOPRIGHT_EN
                if (w_issue && w_jend) w_ns = S_TR;
`else
                w_slast = w_jend;
                if (w_issue && w_jend) w_ns = S_DRAIN;
`endif
            end
`ifdef MB_FETCH_TOPRIGHT_EN
            S_TR: begin
                w_slot  = 1'b1;
                w_issue = w_credit;
                w_kind  = 2'd3;
                w_const = r_y0 == '0;
                w_slast = w_kend;
                w_row   = r_y0 - 1'b1;
                // right frame edge: replicate last top pixel
                if (r_x0 + MW == FW)
                    w_col = FW - 1'b1;
                else
                    w_col = r_x0 + MW + ADDR_W'(r_k);
                if (w_issue && w_kend) w_ns = S_DRAIN;
            end
`endif
            S_DRAIN: begin
                if (w_beat && out_last) begin
                    w_ns     = S_IDLE;
                    w_done_n = 1'b1;
                end
            end
            default: w_ns = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mbn   <= '0;
            r_x0    <= '0;
            r_y0    <= '0;
            r_k     <= '0;
            r_j     <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_ns;
            r_done  <= w_done_n;
            r_err   <= w_err_n;
            if (r_state == S_IDLE && start)
                r_mbn <= mbnumber;
            if (r_state == S_CALC) begin
                r_y0 <= ADDR_W'((32'(r_mbn) / 32'(MPR))
                                * 32'(MB_H));
                r_x0 <= ADDR_W'((32'(r_mbn) % 32'(MPR))
                                * 32'(MB_W));
                r_k  <= '0;
                r_j  <= '0;
            end
            if (w_issue) begin
                if (r_state == S_LEFT) begin
                    r_j <= r_j + 1'b1;
                end else begin
                    r_k <= r_k + 1'b1;
                    if (r_state == S_MB && w_kend)
                        r_j <= r_j + 1'b1;
                end
            end
        end
    end

    // tags travel alongside the memory read so ordering is preserved
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sv <= '0;
            r_sc <= '0;
            r_sl <= '0;
            r_sk <= '0;
        end else begin
            r_sv[0] <= w_issue;
            r_sc[0] <= w_const;
            r_sl[0] <= w_slast;
            r_sk[0] <= w_kind;
            for (int i = 1; i < RD_LAT; i++) begin
                r_sv[i] <= r_sv[i-1];
                r_sc[i] <= r_sc[i-1];
                r_sl[i] <= r_sl[i-1];
                r_sk[i] <= r_sk[i-1];
            end
        end
    end

    assign w_tv    = r_sv[RD_LAT-1];
    assign w_tdata = r_sc[RD_LAT-1] ? 8'd128 : mem_rd_data;
    assign w_fne   = r_cnt != '0;
    assign w_beat  = out_valid & out_ready;
    assign w_pop   = w_beat & w_fne;
    assign w_push  = w_tv & ~(~w_fne & out_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rp  <= '0;
            r_wp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fd[i] <= '0;
                r_fk[i] <= '0;
                r_fl[i] <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_fd[r_wp] <= w_tdata;
                r_fk[r_wp] <= r_sk[RD_LAT-1];
                r_fl[r_wp] <= r_sl[RD_LAT-1];
                r_wp <= (r_wp == PW'(DEPTH-1)) ? '0 : r_wp + 1'b1;
            end
            if (w_pop)
                r_rp <= (r_rp == PW'(DEPTH-1)) ? '0 : r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    assign busy        = r_state != S_IDLE;
    assign done        = r_done;
    assign err         = r_err;
    assign mem_rd_en   = w_issue & ~w_const;
    assign mem_rd_sel  = mem_rd_en & (r_state != S_MB);
    assign mem_rd_addr = mem_rd_en ? (w_row * FW + w_col) : '0;

    // empty FIFO lets the pipeline tail straight through
    assign out_valid = w_fne | w_tv;
    assign out_data  = w_fne ? r_fd[r_rp] :
                       (w_tv ? w_tdata : 8'd0);
    assign out_kind  = w_fne ? r_fk[r_rp] :
                       (w_tv ? r_sk[RD_LAT-1] : 2'd0);
    assign out_last  = w_fne ? r_fl[r_rp] :
                       (w_tv & r_sl[RD_LAT-1]);
endmodule

// File: tb/tb_mb_fetch_engine.sv
// Scoreboard bench for mb_fetch_engine on a 64x32 frame, 16x16 MBs.
// Top-right beats are expected when MB_FETCH_TOPRIGHT_EN is defined.
module tb_mb_fetch_engine;
    localparam int FW  = 64;
    localparam int FH  = 32;
    localparam int MW  = 16;
    localparam int MH  = 16;
    localparam int AW  = 20;
    localparam int NW  = 13;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NW-1:0] mbn = '0;
    logic          busy, done, err;
    logic          mem_rd_en, mem_rd_sel;
    logic [AW-1:0] mem_rd_addr;
    logic [7:0]    mem_rd_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [7:0]    out_data;
    logic [1:0]    out_kind;
    logic          out_last;

    mb_fetch_engine #(
        .FRAME_W(FW), .FRAME_H(FH), .MB_W(MW), .MB_H(MH),
        .ADDR_W(AW), .MBN_W(NW), .RD_LAT(LAT)
    ) dut (
        .clk(clk), .reset(rst), .start(start),
        .mbnumber(mbn), .busy(busy), .done(done), .err(err),
        .mem_rd_en(mem_rd_en), .mem_rd_sel(mem_rd_sel),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_kind(out_kind),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nb = 0;
    int rmode = 0;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] k;
        logic       l;
    } beat_t;

    beat_t         exq[$];
    logic [AW:0]   rdq[$];

    function automatic logic [7:0] spix(int a);
        return 8'((a * 7 + 3) ^ (a >> 6));
    endfunction

    function automatic logic [7:0] rpix(int a);
        return 8'((a * 5 + 11) ^ 8'h3c);
    endfunction

    logic [7:0] d1 = 8'h00;
    logic [7:0] d2 = 8'h00;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en)
            d1 <= mem_rd_sel ? rpix(int'(mem_rd_addr))
                             : spix(int'(mem_rd_addr));
        else
            d1 <= 8'hee;
        d2 <= d1;
    end
    assign mem_rd_data = d2;

    task automatic chk(string nm, logic [31:0] act,
                       logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = (rmode == 0) || (cyc % 3 == 0);
        end
    end

    // monitor: reads, beats and hold-while-stalled
    initial begin
        logic       stall;
        logic [10:0] held;
        beat_t      b;
        logic [AW:0] e;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("hold_valid", 32'(out_valid), 1);
                    chk("hold_beat",
                        32'({out_data, out_kind, out_last}),
                        32'(held));
                end
                if (mem_rd_en) begin
                    chk("read_expected", 32'(rdq.size() != 0), 1);
                    if (rdq.size() != 0) begin
                        e = rdq.pop_front();
                        chk("rd_sel_addr",
                            32'({mem_rd_sel, mem_rd_addr}),
                            32'(e));
                    end
                end
                if (out_valid && out_ready) begin
                    chk("beat_expected", 32'(exq.size() != 0), 1);
                    if (exq.size() != 0) begin
                        b = exq.pop_front();
                        chk("beat",
                            32'({out_data, out_kind, out_last}),
                            32'(b));
                    end
                    nb++;
                end
                stall = out_valid && !out_ready;
                held  = {out_data, out_kind, out_last};
            end
        end
    end

    task automatic push_nb(int x0, int y0, int row, int col,
                           logic [1:0] k, logic avail);
        beat_t b;
        int a;
        a = row * FW + col;
        b.k = k;
        b.l = 1'b0;
        if (avail) begin
            b.d = rpix(a);
            rdq.push_back({1'b1, AW'(a)});
        end else begin
            b.d = 8'd128;
        end
        exq.push_back(b);
    endtask

    task automatic build(int m);
        int x0, y0, a;
        beat_t b;
        x0 = (m % (FW / MW)) * MW;
        y0 = (m / (FW / MW)) * MH;
        for (int j = 0; j < MH; j++)
            for (int k = 0; k < MW; k++) begin
                a = (y0 + j) * FW + x0 + k;
                b.d = spix(a);
                b.k = 2'd0;
                b.l = 1'b0;
                exq.push_back(b);
                rdq.push_back({1'b0, AW'(a)});
            end
        for (int k = 0; k < MW; k++)
            push_nb(x0, y0, y0 - 1, x0 + k, 2'd1, y0 != 0);
        for (int j = 0; j < MH; j++)
            push_nb(x0, y0, y0 + j, x0 - 1, 2'd2, x0 != 0);
`ifdef MB_FETCH_TOPRIGHT_EN
        for (int k = 0; k < MW; k++)
            push_nb(x0, y0, y0 - 1,
                    (x0 + MW == FW) ? FW - 1 : x0 + MW + k,
                    2'd3, y0 != 0);
`endif
        exq[exq.size() - 1].l = 1'b1;
    endtask

    task automatic run_job(int m, int mode, int abort_at,
                           logic exp_err);
        int s, b0, fc;
        rmode = mode;
        if (!exp_err) build(m);
        @(posedge clk);
        #1;
        mbn   = NW'(m);
        start = 1'b1;
        s     = cyc;
        b0    = nb;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 1);
        if (abort_at > 0) begin
            for (int i = 0; i < 20000; i++) begin
                @(posedge clk);
                if (nb - b0 >= abort_at) break;
            end
            chk("abort_point", 32'(nb - b0 >= abort_at), 1);
            #1;
            rst = 1'b1;
            exq.delete();
            rdq.delete();
            @(negedge clk);
            chk("abort_outs",
                32'({busy, done, err, mem_rd_en, out_valid}), 0);
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            return;
        end
        if (!exp_err) begin
            fc = -1;
            for (int i = 0; i < 50; i++) begin
                if (out_valid) begin
                    fc = cyc;
                    break;
                end
                @(negedge clk);
            end
            chk("first_beat_lat", 32'(fc - s), LAT + 2);
        end
        for (int i = 0; i < 20000; i++) begin
            if (done) break;
            @(negedge clk);
        end
        chk("done_seen", 32'(done), 1);
        chk("err", 32'(err), 32'(exp_err));
        chk("busy_at_done", 32'(busy), 0);
        chk("beats_left", 32'(exq.size()), 0);
        chk("reads_left", 32'(rdq.size()), 0);
        if (exp_err) chk("err_lat", 32'(cyc - s), 2);
        @(negedge clk);
        chk("done_pulse", 32'(done), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outs",
            32'({busy, done, err, mem_rd_en, mem_rd_sel,
                 out_valid, out_last, out_kind}), 0);
        chk("reset_data", 32'({out_data, mem_rd_addr}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_job(0, 0, 0, 1'b0);
        run_job(5, 0, 0, 1'b0);
        run_job(8, 0, 0, 1'b1);
        run_job(5, 1, 0, 1'b0);
        run_job(7, 0, 0, 1'b0);
        run_job(5, 0, 100, 1'b0);
        run_job(0, 0, 0, 1'b0);
        run_job(3, 1, 0, 1'b0);
        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
